sram_access_arbiter: RTL

Shares the single-port external SRAM between the instruction-fetch port (IF) and the data-memory port (MEM) of the 5-stage pipeline. Each SRAM access takes a fixed number of wait cycles. The block sequences every access through a small state machine and returns a one-cycle ready pulse to the granted requester. It also generates per-stage stall signals that freeze the pipeline while an access is outstanding, and it sits beside the hazard detection logic in the pipeline's freeze chain.

---
 rtl/sram_access_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//
// Shares one single-port external SRAM between the instruction-fetch (IF)
// and data-memory (MEM) ports of the 5-stage pipeline. Each transfer runs
// for WAIT_CYCLES SRAM cycles, then the granted requester gets a one-cycle
// ready pulse. The stall outputs freeze the matching pipeline stage while
// its request is outstanding.
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | no transfer; samples requests, MEM has priority over IF
//   S_ACCESS | SRAM strobed from latched operands, down-counter running
//   S_DONE   | one cycle; ready pulse to the granted port if still requesting
//
// Parameters:
//   WAIT_CYCLES : SRAM cycles per transfer (1..15)
//   ADDR_W      : SRAM word-address width
//
// Ports:
//   clk, rst                   : pipeline clock, synchronous active-high reset
//   if_req, if_addr            : IF read request and byte address
//   if_rdata, if_ready         : fetched word and completion pulse
//   if_stall                   : IF stage freeze
//   mem_r_en, mem_w_en         : MEM load / store request (mutually exclusive)
//   mem_addr, mem_wdata        : MEM byte address and store data
//   mem_rdata, mem_ready       : load data and completion pulse
//   mem_stall                  : MEM stage freeze
//   sram_addr, sram_wdata      : SRAM word address and write data
//   sram_rdata                 : SRAM read data
//   sram_we, sram_oe           : SRAM write strobe and output enable

module sram_access_arbiter #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_stall,

    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,

    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_we,
    output logic              sram_oe
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic       GRANT_IF  = 1'b0;
    localparam logic       GRANT_MEM = 1'b1;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                grant, grant_nxt;
    logic                wr, wr_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [31:0]         wdata_q, wdata_nxt;
    logic [31:0]         rdata_q, rdata_nxt;
    logic                mem_req;

    // Byte-offset and high address bits never reach the SRAM.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    assign mem_req = mem_r_en | mem_w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            grant   <= GRANT_IF;
            wr      <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            grant   <= grant_nxt;
            wr      <= wr_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        wr_nxt    = wr;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rdata_nxt = rdata_q;

        case (state)
            S_IDLE: begin
                // MEM first: the older instruction must drain before fetch.
                if (mem_req) begin
                    grant_nxt = GRANT_MEM;
                    addr_nxt  = mem_addr[ADDR_W+1:2];
                    wdata_nxt = mem_wdata;
                    wr_nxt    = mem_w_en;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = S_ACCESS;
                end else if (if_req) begin
                    grant_nxt = GRANT_IF;
                    addr_nxt  = if_addr[ADDR_W+1:2];
                    wr_nxt    = 1'b0;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // A withdrawn request does not abort; the cycle runs out.
                if (cnt == 4'd0) begin
                    if (!wr) begin
                        rdata_nxt = sram_rdata;
                    end
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_we    = (state == S_ACCESS) &  wr;
    assign sram_oe    = (state == S_ACCESS) & ~wr;

    // Ready is suppressed when the owner has dropped its request (flush).
    assign if_ready   = (state == S_DONE) & (grant == GRANT_IF)  & if_req;
    assign mem_ready  = (state == S_DONE) & (grant == GRANT_MEM) & mem_req;

    assign if_rdata   = rdata_q;
    assign mem_rdata  = rdata_q;

    assign if_stall   = if_req  & ~if_ready;
    assign mem_stall  = mem_req & ~mem_ready;

endmodule
